// File: rtl/cell_crossbar_rr.sv
// cell_crossbar_rr: N_PORTS x N_PORTS cell crossbar.
// Every output owns a registered holding slot and a round-robin arbiter, so an
// output that is backpressured only stalls the inputs aiming at it. Inputs
// whose destination is out of range (possible only for non power-of-2
// N_PORTS) are accepted immediately and the cell is discarded.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid_i / in_ready_o       per-input handshake (in_ready_o is combinational)
//   in_cell_i, in_dest_i          input cells and destinations, port i at slice i
//   out_valid_o / out_ready_i     per-output handshake
//   out_cell_o                    output slot contents, slot o at slice o
//   drop_cnt_o, stall_cnt_o       saturating drop and stall statistics

// Per-output slot: round-robin pick among requesters, registered cell slot.
module cell_crossbar_rr_slot #(
  parameter int N_PORTS = 4,
  parameter int CELL_W  = 424,
  parameter int DEST_W  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               req_i,
  input  logic [N_PORTS-1:0][CELL_W-1:0]   cells_i,
  input  logic                             out_ready_i,
  output logic [N_PORTS-1:0]               gnt_o,
  output logic                             out_valid_o,
  output logic [CELL_W-1:0]                out_cell_o
);
  logic              vld_q;
  logic [CELL_W-1:0] cell_q;
  logic [DEST_W-1:0] ptr_q;
  logic              free, found;
  logic [DEST_W-1:0] win, cand;
  int                idx;

  // Slot may drain and reload in the same cycle.
  assign free = !vld_q || out_ready_i;

  // First requester at or after ptr_q, wrapping mod N_PORTS.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      cand = DEST_W'(idx);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    gnt_o = '0;
    if (free && found) gnt_o[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      cell_q <= '0;
      ptr_q  <= '0;
    end else if (free) begin
      vld_q <= found;
      if (found) begin
        cell_q <= cells_i[win];
        ptr_q  <= (win == DEST_W'(N_PORTS-1)) ? '0 : win + DEST_W'(1);
      end
    end
  end

  assign out_valid_o = vld_q;
  assign out_cell_o  = cell_q;
endmodule

module cell_crossbar_rr #(
  parameter int N_PORTS = 4,
  parameter int CELL_W  = 424,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          in_valid_i,
  output logic [N_PORTS-1:0]          in_ready_o,
  input  logic [N_PORTS*CELL_W-1:0]   in_cell_i,
  input  logic [N_PORTS*((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] in_dest_i,
  output logic [N_PORTS-1:0]          out_valid_o,
  input  logic [N_PORTS-1:0]          out_ready_i,
  output logic [N_PORTS*CELL_W-1:0]   out_cell_o,
  output logic [CNT_W-1:0]            drop_cnt_o,
  output logic [CNT_W-1:0]            stall_cnt_o
);
  localparam int DEST_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [CNT_W+4:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};

  logic [N_PORTS-1:0][CELL_W-1:0]  cells, ocells;
  logic [N_PORTS-1:0][DEST_W-1:0]  dest;
  logic [N_PORTS-1:0][N_PORTS-1:0] req, gnt;   // [output][input]
  logic [N_PORTS-1:0]              oor;
  logic [CNT_W-1:0]                drop_q, drop_d, stall_q, stall_d;
  logic [CNT_W+4:0]                drop_sum;

  assign cells      = in_cell_i;
  assign dest       = in_dest_i;
  assign out_cell_o = ocells;

  always_comb begin
    for (int o = 0; o < N_PORTS; o++)
      for (int i = 0; i < N_PORTS; i++)
        req[o][i] = in_valid_i[i] && (dest[i] == DEST_W'(o));
  end

  // Out-of-range destinations only exist when the dest field has spare codes.
  if (N_PORTS < (1 << DEST_W)) begin : g_oor
    always_comb begin
      for (int i = 0; i < N_PORTS; i++)
        oor[i] = in_valid_i[i] && (dest[i] > DEST_W'(N_PORTS-1));
    end
  end else begin : g_no_oor
    assign oor = '0;
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_slot
    cell_crossbar_rr_slot #(.N_PORTS(N_PORTS), .CELL_W(CELL_W), .DEST_W(DEST_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req[o]),
      .cells_i    (cells),
      .out_ready_i(out_ready_i[o]),
      .gnt_o      (gnt[o]),
      .out_valid_o(out_valid_o[o]),
      .out_cell_o (ocells[o])
    );
  end

  always_comb begin
    in_ready_o = oor;
    for (int o = 0; o < N_PORTS; o++)
      for (int i = 0; i < N_PORTS; i++)
        in_ready_o[i] = in_ready_o[i] | gnt[o][i];
  end

  // Several inputs can drop in one cycle; add then clamp.
  always_comb begin
    drop_sum = {5'b0, drop_q};
    for (int i = 0; i < N_PORTS; i++)
      drop_sum = drop_sum + (CNT_W+5)'(oor[i]);
    drop_d = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    stall_d = stall_q;
    if (|(in_valid_i & ~in_ready_o) && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q  <= '0;
      stall_q <= '0;
    end else begin
      drop_q  <= drop_d;
      stall_q <= stall_d;
    end
  end

  assign drop_cnt_o  = drop_q;
  assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_cell_crossbar_rr.sv
// Bench for cell_crossbar_rr: a 4-port instance (k=0) and a 3-port instance
// with 2-bit counters (k=1), both checked every cycle against a cycle-level
// model built from the arbitration rules, plus per (input,output) scoreboards.
// Cells are encoded {src[3:0], seq[11:0]}.
module tb_cell_crossbar_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]        iv[2];
  logic [3:0][15:0]  ic[2];
  logic [3:0][1:0]   id[2];
  logic [3:0]        ordy[2];

  logic [3:0] ir0, ov0;
  logic [2:0] ir1, ov1;
  logic [3:0][15:0] oc0;
  logic [2:0][15:0] oc1;
  logic [15:0] dc0, sc0;
  logic [1:0]  dc1, sc1;

  logic [3:0]       ir[2], ov[2];
  logic [3:0][15:0] oc[2];
  logic [31:0]      dcnt[2], scnt[2];

  cell_crossbar_rr #(.N_PORTS(4), .CELL_W(16), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid_i(iv[0]), .in_ready_o(ir0), .in_cell_i(ic[0]),
    .in_dest_i(id[0]), .out_valid_o(ov0), .out_ready_i(ordy[0]), .out_cell_o(oc0),
    .drop_cnt_o(dc0), .stall_cnt_o(sc0));

  cell_crossbar_rr #(.N_PORTS(3), .CELL_W(16), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid_i(iv[1][2:0]), .in_ready_o(ir1), .in_cell_i(ic[1][2:0]),
    .in_dest_i(id[1][2:0]), .out_valid_o(ov1), .out_ready_i(ordy[1][2:0]), .out_cell_o(oc1),
    .drop_cnt_o(dc1), .stall_cnt_o(sc1));

  assign ir[0] = ir0;  assign ir[1] = {1'b0, ir1};
  assign ov[0] = ov0;  assign ov[1] = {1'b0, ov1};
  assign oc[0] = oc0;  assign oc[1] = {16'h0, oc1};
  assign dcnt[0] = {16'h0, dc0}; assign dcnt[1] = {30'h0, dc1};
  assign scnt[0] = {16'h0, sc0}; assign scnt[1] = {30'h0, sc1};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  mv[2];
  logic [15:0] mc[2][4];
  int          mp[2][4];
  int          mdrop[2], mstall[2];
  logic [3:0]  mrdy[2];
  int          q[2][4][4][$];     // [k][input][output] accepted seqs in flight
  int          waits[2][4][4];    // [k][output][input] grants seen while waiting
  int          seq[2][4];

  task automatic model_step(input int k);
    int n, cmax, drops, w, i, src, e;
    logic [3:0] rdy, nv;
    logic [15:0] ncell[4];
    n    = (k == 0) ? 4 : 3;
    cmax = (k == 0) ? 65535 : 3;
    if (rst) begin
      chk($sformatf("rst_ov[%0d]", k), ov[k], 0);
      chk($sformatf("rst_drop[%0d]", k), dcnt[k], 0);
      chk($sformatf("rst_stall[%0d]", k), scnt[k], 0);
      mv[k] = '0; mrdy[k] = '0; mdrop[k] = 0; mstall[k] = 0;
      for (int o = 0; o < 4; o++) begin
        mc[k][o] = '0; mp[k][o] = 0;
        for (int j = 0; j < 4; j++) begin q[k][j][o].delete(); waits[k][o][j] = 0; end
      end
      return;
    end
    rdy = '0; drops = 0;
    for (int j = 0; j < n; j++)
      if (iv[k][j] && int'(id[k][j]) >= n) begin rdy[j] = 1'b1; drops++; end
    nv = mv[k];
    for (int o = 0; o < 4; o++) ncell[o] = mc[k][o];
    for (int o = 0; o < n; o++) begin
      if (!mv[k][o] || ordy[k][o]) begin
        w = -1;
        for (int j = 0; j < n; j++) begin
          i = (mp[k][o] + j) % n;
          if (w < 0 && iv[k][i] && int'(id[k][i]) == o) w = i;
        end
        if (w >= 0) begin
          for (int j = 0; j < n; j++)
            if (j != w && iv[k][j] && int'(id[k][j]) == o) begin
              waits[k][o][j]++;
              if (waits[k][o][j] > n - 1)
                chk($sformatf("fair[%0d] o%0d i%0d", k, o, j), waits[k][o][j], n - 1);
            end
          waits[k][o][w] = 0;
          rdy[w] = 1'b1; nv[o] = 1'b1; ncell[o] = ic[k][w];
          mp[k][o] = (w + 1) % n;
          q[k][w][o].push_back(int'(ic[k][w][11:0]));
        end else nv[o] = 1'b0;
      end
    end
    chk($sformatf("in_ready[%0d]", k), ir[k], rdy);
    chk($sformatf("out_valid[%0d]", k), ov[k], mv[k]);
    for (int o = 0; o < n; o++)
      chk($sformatf("out_cell[%0d][%0d]", k, o), oc[k][o], mc[k][o]);
    chk($sformatf("drop_cnt[%0d]", k), dcnt[k], mdrop[k]);
    chk($sformatf("stall_cnt[%0d]", k), scnt[k], mstall[k]);
    // scoreboard on the DUT's drained cells
    for (int o = 0; o < n; o++)
      if (ov[k][o] && ordy[k][o]) begin
        src = int'(oc[k][o][15:12]);
        if (src >= n || q[k][src][o].size() == 0)
          chk($sformatf("sb_unexpected[%0d] o%0d", k, o), oc[k][o], 32'hFFFF_FFFF);
        else begin
          e = q[k][src][o].pop_front();
          chk($sformatf("sb_order[%0d] o%0d i%0d", k, o, src), oc[k][o][11:0], e);
        end
      end
    if (|(iv[k] & ~rdy)) mstall[k] = (mstall[k] < cmax) ? mstall[k] + 1 : cmax;
    mdrop[k] = (mdrop[k] + drops > cmax) ? cmax : mdrop[k] + drops;
    mv[k] = nv;
    for (int o = 0; o < 4; o++) mc[k][o] = ncell[o];
    mrdy[k] = rdy;
  endtask

  initial forever begin
    @(negedge clk);
    model_step(0);
    model_step(1);
  end

  // ---------------- stimulus ----------------
  task automatic new_cell(input int k, input int i);
    ic[k][i] = {4'(i), 12'(seq[k][i])};
    seq[k][i]++;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    iv[0] = '0; iv[1] = '0;
    ordy[0] = 4'hF; ordy[1] = 4'hF;
    rst = 1'b1;
    #1;
    chk("async_rst_ov0", ov[0], 0);
    chk("async_rst_ov1", ov[1], 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [15:0] c0, c3, c1;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = '0; ic[k] = '0; id[k] = '0; ordy[k] = 4'hF;
      for (int i = 0; i < 4; i++) seq[k][i] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("init_ov0", ov[0], 0); chk("init_drop0", dcnt[0], 0); chk("init_stall0", scnt[0], 0);
    chk("init_ov1", ov[1], 0); chk("init_drop1", dcnt[1], 0);
    rst = 1'b0;

    // permutation: input i -> output 3-i, all accepted together
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin iv[0][i] = 1'b1; id[0][i] = 2'(3 - i); new_cell(0, i); end
    c0 = ic[0][0]; c3 = ic[0][3];
    @(negedge clk); chk("perm_ready", ir[0], 4'hF);
    @(posedge clk); #1; iv[0] = '0;
    @(negedge clk);
    chk("perm_valid", ov[0], 4'hF);
    chk("perm_cell3", oc[0][3], c0);
    chk("perm_cell0", oc[0][0], c3);

    // all inputs hammer output 1: grants rotate 0,1,2,3 and stall counts every cycle
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin iv[0][i] = 1'b1; id[0][i] = 2'd1; new_cell(0, i); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr_grant c%0d", c), ir[0], 32'(1) << (c % 4));
      chk($sformatf("rr_stall c%0d", c), scnt[0], c);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (mrdy[0][i]) new_cell(0, i);
    end
    iv[0] = '0;

    // output 2 blocked: input 0 waits, held cell stable, accepted when ready rises
    do_reset();
    @(posedge clk); #1;
    ordy[0] = 4'b1011; iv[0][1] = 1'b1; id[0][1] = 2'd2; new_cell(0, 1); c1 = ic[0][1];
    @(negedge clk); chk("blk_load", ir[0][1], 1);
    @(posedge clk); #1;
    iv[0][1] = 1'b0; iv[0][0] = 1'b1; id[0][0] = 2'd2; new_cell(0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("blk_ready c%0d", c), ir[0][0], 0);
      chk($sformatf("blk_hold c%0d", c), oc[0][2], c1);
      @(posedge clk); #1;
    end
    ordy[0] = 4'hF;
    @(negedge clk); chk("blk_release", ir[0][0], 1);
    @(posedge clk); #1; iv[0] = '0;

    // N=3, dest 3 is out of range: accepted and dropped, counter saturates at 3
    do_reset();
    @(posedge clk); #1;
    iv[1][1] = 1'b1; id[1][1] = 2'd3; new_cell(1, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("drop_ready c%0d", c), ir[1], 3'b010);
      chk($sformatf("drop_cnt c%0d", c), dcnt[1], (c < 3) ? c : 3);
      chk($sformatf("drop_novalid c%0d", c), ov[1], 0);
      @(posedge clk); #1; new_cell(1, 1);
    end
    @(negedge clk); chk("drop_sat", dcnt[1], 3);
    @(posedge clk); #1; iv[1] = '0;

    // random traffic on both instances, with a reset in the middle
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) do_reset();
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < ((k == 0) ? 4 : 3); i++)
          if (!iv[k][i] || mrdy[k][i]) begin
            iv[k][i] = ($urandom_range(9) < 6);
            id[k][i] = 2'($urandom_range(3));
            new_cell(k, i);
          end
        for (int o = 0; o < ((k == 0) ? 4 : 3); o++) ordy[k][o] = ($urandom_range(9) < 7);
      end
    end

    // drain and confirm nothing is left in flight
    @(posedge clk); #1;
    iv[0] = '0; iv[1] = '0; ordy[0] = 4'hF; ordy[1] = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        for (int o = 0; o < 4; o++)
          chk($sformatf("sb_leftover[%0d] i%0d o%0d", k, i, o), q[k][i][o].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
